ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter TIMEOUT, default 20000, is the number of clk_sys cycles without a ps2_clk falling edge after which a started frame is abandoned.
REQ-002 Port clk_sys, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port ps2_clk, input, 1 bit: PS/2 keyboard clock, asynchronous to clk_sys; idles high.
REQ-005 Port ps2_data, input, 1 bit: PS/2 keyboard data, asynchronous to clk_sys; idles high.
REQ-006 Port key_strobe, output, 1 bit: one-cycle pulse marking a complete decoded key event.
REQ-007 Port key_code, output, 8 bits: scancode of the event; holds its value until the next key_strobe.
REQ-008 Port key_ext, output, 1 bit: an E0 prefix preceded the code.
REQ-009 Port key_rel, output, 1 bit: an F0 prefix preceded the code (key release).
REQ-010 Port frame_err, output, 1 bit: one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 ps2_clk and ps2_data shall each pass through a 2-flop synchroniser; a falling edge is the synchronised clock going from 1 to 0.
REQ-012 The frame FSM shall have the states IDLE, DATA, PARITY and STOP, and all bit sampling shall use synchronised ps2_data on a falling edge.
REQ-013 In IDLE, an edge with data=0 (the start bit) shall enter DATA with bit count 0; an edge with data=1 shall be ignored.
REQ-014 In DATA, 8 bits shall be shifted in LSB first; the eighth edge shall enter PARITY.
REQ-015 In PARITY, the parity bit shall be sampled and the FSM shall enter STOP; parity is odd, so the XOR of the 8 data bits and the parity bit must equal 1.
REQ-016 In STOP, the FSM shall return to IDLE; the frame is valid only if the stop bit is 1 and parity is good.
REQ-017 If the frame is invalid, frame_err shall pulse for 1 cycle, the byte shall be discarded, and the ext and rel prefix flags shall be cleared.
REQ-018 Timeout: in any state other than IDLE, TIMEOUT consecutive cycles with no edge shall force IDLE, pulse frame_err and clear both prefix flags; the counter shall restart on every edge.
REQ-019 On a valid byte 0xE0, the internal ext flag shall be set and no strobe shall be issued.
REQ-020 On a valid byte 0xF0, the internal rel flag shall be set and no strobe shall be issued.
REQ-021 On any other valid byte (0xE1 included), key_code, key_ext and key_rel shall be loaded and key_strobe shall pulse; both flags shall clear in the same cycle.
REQ-022 Latency: key_strobe or frame_err shall assert exactly 3 clk_sys cycles after the first rising clk_sys edge that samples the stop-bit ps2_clk low.
REQ-023 key_strobe and frame_err shall never be asserted in the same cycle, and neither shall be high for longer than 1 cycle.
REQ-024 Operation is guaranteed for ps2_clk half-periods of at least 4 clk_sys cycles.
REQ-025 The timeout counter shall saturate and shall not wrap.

Reset
REQ-026 On reset, outputs shall be key_strobe=0, frame_err=0, key_code=0x00, key_ext=0, key_rel=0.
REQ-027 On reset, the FSM shall go to IDLE and the bit count, shift register, prefix flags and timeout counter shall clear.
REQ-028 On reset, the synchroniser flops shall preset to 1, so that no spurious edge is seen on release.
REQ-029 Reset asserted mid-frame shall discard the partial frame without a frame_err pulse.

Structure
REQ-030 The shared package mist_pkg shall hold the FSM state enum and the constants PS2_PFX_EXT=8'hE0 and PS2_PFX_REL=8'hF0.
REQ-031 A sub-module ps2_sync shall contain the 2-flop synchronisers and the falling-edge detector, and shall output sync_data and clk_fall.

Verification
REQ-032 Frame 0x1C with good parity -> one key_strobe with key_code=0x1C, key_ext=0, key_rel=0, at the latency given in REQ-022.
REQ-033 Frames F0,1C -> a single strobe with key_code=0x1C, key_rel=1, key_ext=0, and no strobe on the F0 frame.
REQ-034 Frames E0,F0,75 -> a single strobe with key_code=0x75, key_ext=1, key_rel=1; a following 0x29 frame -> ext=0, rel=0.
REQ-035 0x1C sent with an inverted parity bit -> one frame_err pulse and no strobe; a following good 0x29 frame -> a strobe with key_code=0x29.
REQ-036 Start bit plus 5 data bits, then idle -> frame_err exactly TIMEOUT cycles after the last edge; a following good 0x1C frame is decoded.
REQ-037 Reset pulsed after 4 data bits of an E0 prefix, then frame 0x1C -> a strobe with key_ext=0 and no frame_err.

Source files
------------

// File: rtl/mist_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, scancode prefixes and
// the odd-parity check used when a frame completes.
package mist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
    localparam int         PS2_DATA_BITS = 8;

    // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Decoded key-event bundle produced by ps2_kbd_rx; master drives, slave observes.
interface ps2_kbd_rx_if;

    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_rel;
    logic       frame_err;

    modport master (
        output key_strobe,
        output key_code,
        output key_ext,
        output key_rel,
        output frame_err
    );

    modport slave (
        input key_strobe,
        input key_code,
        input key_ext,
        input key_rel,
        input frame_err
    );

endinterface

// File: rtl/ps2_sync.sv
// Brings ps2_clk/ps2_data into clk_sys and produces a registered one-cycle
// pulse on each synchronised ps2_clk falling edge, aligned with the data sample.
module ps2_sync (
    input  logic clk_sys,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sync_data,
    output logic clk_fall
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    logic       r_clk_fall;
    logic       r_sync_data;

    // Presetting to the idle-high level keeps reset release from looking like an edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
            r_clk_fall  <= 1'b0;
            r_sync_data <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= r_clk_sync[1];
            r_clk_fall  <= r_clk_prev & ~r_clk_sync[1];
            r_sync_data <= r_data_sync[1];
        end
    end

    assign sync_data = r_sync_data;
    assign clk_fall  = r_clk_fall;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 bytes, folds E0/F0 prefixes into a
// single key event and reports parity, stop-bit and timeout errors.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (edge with data low)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling the odd-parity bit
// ST_STOP   | sampling the stop bit, then decode or flag an error
module ps2_kbd_rx
    import mist_pkg::*;
#(
    parameter int TIMEOUT = 20000
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.master kbd
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(PS2_DATA_BITS - 1);

    logic             w_sync_data;
    logic             w_clk_fall;
    logic             w_frame_ok;

    ps2_state_t       r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic             r_ext;
    logic             r_rel;
    logic [TMO_W-1:0] r_tmo;

    logic             r_key_strobe;
    logic             r_frame_err;
    logic [7:0]       r_key_code;
    logic             r_key_ext;
    logic             r_key_rel;

    ps2_sync u_sync (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .sync_data (w_sync_data),
        .clk_fall  (w_clk_fall)
    );

    // Evaluated while in ST_STOP: w_sync_data is then the stop bit.
    assign w_frame_ok = w_sync_data & ps2_parity_ok(r_shift, r_parity);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_ext        <= 1'b0;
            r_rel        <= 1'b0;
            r_tmo        <= '0;
            r_key_strobe <= 1'b0;
            r_frame_err  <= 1'b0;
            r_key_code   <= '0;
            r_key_ext    <= 1'b0;
            r_key_rel    <= 1'b0;
        end else begin
            r_key_strobe <= 1'b0;
            r_frame_err  <= 1'b0;

            // Down-counting watchdog, reloaded on every edge, parked at zero.
            if (w_clk_fall) begin
                r_tmo <= TMO_LOAD;
            end else if (r_state != ST_IDLE && r_tmo != '0) begin
                r_tmo <= r_tmo - TMO_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_clk_fall && !w_sync_data) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_clk_fall) begin
                        r_shift   <= {w_sync_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_clk_fall) begin
                        r_parity <= w_sync_data;
                        r_state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_clk_fall) begin
                        r_state <= ST_IDLE;
                        if (!w_frame_ok) begin
                            r_frame_err <= 1'b1;
                            r_ext       <= 1'b0;
                            r_rel       <= 1'b0;
                        end else if (r_shift == PS2_PFX_EXT) begin
                            r_ext <= 1'b1;
                        end else if (r_shift == PS2_PFX_REL) begin
                            r_rel <= 1'b1;
                        end else begin
                            r_key_strobe <= 1'b1;
                            r_key_code   <= r_shift;
                            r_key_ext    <= r_ext;
                            r_key_rel    <= r_rel;
                            r_ext        <= 1'b0;
                            r_rel        <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Abandon a stalled frame; no edge this cycle, so no other branch fired.
            if (r_state != ST_IDLE && !w_clk_fall && r_tmo == '0) begin
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_rel       <= 1'b0;
            end
        end
    end

    assign kbd.key_strobe = r_key_strobe;
    assign kbd.key_code   = r_key_code;
    assign kbd.key_ext    = r_key_ext;
    assign kbd.key_rel    = r_key_rel;
    assign kbd.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed table of frame sequences,
// randomized prefix/code traffic against a protocol-level model, and
// hand-written timeout and mid-frame reset sequences.
module tb_ps2_kbd_rx;

    localparam int TMO  = 300;
    localparam int HALF = 6;

    logic clk_sys  = 1'b0;
    logic reset    = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_kbd_rx_if kbd ();

    ps2_kbd_rx #(.TIMEOUT(TMO)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kbd      (kbd)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] code;
        bit         ext;
        bit         rel;
    } ev_t;

    typedef struct {
        int              nb;
        logic [2:0][7:0] seq;
        bit              bad_par;
        bit              bad_stop;
        bit              e_err;
        logic [7:0]      e_code;
        bit              e_ext;
        bit              e_rel;
    } vec_t;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_err = 0;
    ev_t        obs_q[$];
    ev_t        exp_q[$];
    bit         prev_s = 1'b0;
    bit         prev_e = 1'b0;
    bit         m_ext = 1'b0;
    bit         m_rel = 1'b0;
    logic [7:0] m_code = 8'h00;
    vec_t       vecs[12];

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input string detail);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Event recorder plus pulse-shape checks on every cycle that carries an event.
    always @(negedge clk_sys) begin
        if (reset) begin
            prev_s = 1'b0;
            prev_e = 1'b0;
        end else begin
            if (kbd.key_strobe || kbd.frame_err) begin
                chk(!(kbd.key_strobe && kbd.frame_err) && !(kbd.key_strobe && prev_s)
                    && !(kbd.frame_err && prev_e), "pulse_shape",
                    $sformatf("got strobe=%0b err=%0b (prev %0b/%0b), expected single exclusive pulses",
                              kbd.key_strobe, kbd.frame_err, prev_s, prev_e));
                obs_q.push_back('{cyc, kbd.frame_err, kbd.key_code, kbd.key_ext, kbd.key_rel});
            end
            prev_s = kbd.key_strobe;
            prev_e = kbd.frame_err;
        end
    end

    function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input bit bp, input bit bs, input bit ee,
                                input logic [7:0] ec, input bit ex, input bit er);
        vec_t v;
        v.nb = nb; v.seq = {b2, b1, b0}; v.bad_par = bp; v.bad_stop = bs;
        v.e_err = ee; v.e_code = ec; v.e_ext = ex; v.e_rel = er;
        return v;
    endfunction

    // Protocol-level model: prefixes accumulate, any other good byte is an event.
    task automatic model_frame(input logic [7:0] b, input bit ok, input int stop_cyc);
        if (!ok) begin
            exp_q.push_back('{stop_cyc + 4, 1'b1, 8'h00, 1'b0, 1'b0});
            m_ext = 1'b0; m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            exp_q.push_back('{stop_cyc + 4, 1'b0, b, m_ext, m_rel});
            m_code = b; m_ext = 1'b0; m_rel = 1'b0;
        end
    endtask

    // Starts and ends on a negedge; fall_cyc is the cycle count when ps2_clk was driven low.
    task automatic ps2_bit(input logic d, output int fall_cyc);
        ps2_data = d;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              output int stop_cyc);
        int   fc;
        logic p;
        logic s;
        p = (~(^b)) ^ bad_par;
        s = !bad_stop;
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], fc);
        ps2_bit(p, fc);
        ps2_bit(s, stop_cyc);
        repeat (HALF) @(negedge clk_sys);
        model_frame(b, !(bad_par || bad_stop), stop_cyc);
    endtask

    task automatic check_events(input string name, input int wait_cyc);
        ev_t o;
        ev_t e;
        repeat (wait_cyc) @(negedge clk_sys);
        chk(obs_q.size() == exp_q.size(), {name, "_count"},
            $sformatf("got %0d events, expected %0d", obs_q.size(), exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk(o.cyc == e.cyc && o.err == e.err &&
                (e.err || (o.code == e.code && o.ext == e.ext && o.rel == e.rel)), name,
                $sformatf("got cyc=%0d err=%0b code=%02h ext=%0b rel=%0b, expected cyc=%0d err=%0b code=%02h ext=%0b rel=%0b",
                          o.cyc, o.err, o.code, o.ext, o.rel, e.cyc, e.err, e.code, e.ext, e.rel));
        end
        obs_q.delete();
        exp_q.delete();
        chk(kbd.key_code === m_code, {name, "_hold"},
            $sformatf("got key_code=%02h, expected %02h", kbd.key_code, m_code));
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset    = 1'b0;
        m_ext = 1'b0; m_rel = 1'b0; m_code = 8'h00;
        repeat (4) @(negedge clk_sys);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         sc;
        int         fc;
        int         r;
        bit         bp;
        bit         last;
        logic [7:0] code;
        logic [7:0] pe;
        ev_t        o;

        vecs[0]  = mk(1, 8'h1C, 8'h00, 8'h00, 0, 0, 0, 8'h1C, 0, 0);
        vecs[1]  = mk(2, 8'hF0, 8'h1C, 8'h00, 0, 0, 0, 8'h1C, 0, 1);
        vecs[2]  = mk(3, 8'hE0, 8'hF0, 8'h75, 0, 0, 0, 8'h75, 1, 1);
        vecs[3]  = mk(1, 8'h29, 8'h00, 8'h00, 0, 0, 0, 8'h29, 0, 0);
        vecs[4]  = mk(1, 8'h1C, 8'h00, 8'h00, 1, 0, 1, 8'h00, 0, 0);
        vecs[5]  = mk(1, 8'h29, 8'h00, 8'h00, 0, 0, 0, 8'h29, 0, 0);
        vecs[6]  = mk(2, 8'hE0, 8'h5A, 8'h00, 0, 1, 1, 8'h00, 0, 0);
        vecs[7]  = mk(1, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 8'h5A, 0, 0);
        vecs[8]  = mk(1, 8'hE1, 8'h00, 8'h00, 0, 0, 0, 8'hE1, 0, 0);
        vecs[9]  = mk(2, 8'hE0, 8'h14, 8'h00, 0, 0, 0, 8'h14, 1, 0);
        vecs[10] = mk(2, 8'hF0, 8'hE0, 8'h00, 1, 0, 1, 8'h00, 0, 0);
        vecs[11] = mk(1, 8'h12, 8'h00, 8'h00, 0, 0, 0, 8'h12, 0, 0);

        reset = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk(kbd.key_strobe === 1'b0, "rst_strobe", $sformatf("got %b, expected 0", kbd.key_strobe));
        chk(kbd.frame_err === 1'b0, "rst_err", $sformatf("got %b, expected 0", kbd.frame_err));
        chk(kbd.key_code === 8'h00, "rst_code", $sformatf("got %h, expected 00", kbd.key_code));
        chk(kbd.key_ext === 1'b0, "rst_ext", $sformatf("got %b, expected 0", kbd.key_ext));
        chk(kbd.key_rel === 1'b0, "rst_rel", $sformatf("got %b, expected 0", kbd.key_rel));
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk(obs_q.size() == 0, "rst_release", $sformatf("got %0d events, expected 0", obs_q.size()));

        for (int v = 0; v < 12; v++) begin
            for (int k = 0; k < vecs[v].nb; k++) begin
                last = (k == vecs[v].nb - 1);
                send_frame(vecs[v].seq[k], vecs[v].bad_par && last, vecs[v].bad_stop && last, sc);
            end
            repeat (4) @(negedge clk_sys);
            chk(obs_q.size() == 1, $sformatf("vec%0d_count", v),
                $sformatf("got %0d events, expected 1", obs_q.size()));
            if (obs_q.size() >= 1) begin
                o = obs_q[0];
                chk(o.cyc == sc + 4 && o.err == vecs[v].e_err &&
                    (vecs[v].e_err || (o.code == vecs[v].e_code && o.ext == vecs[v].e_ext &&
                                       o.rel == vecs[v].e_rel)),
                    $sformatf("vec%0d", v),
                    $sformatf("got cyc=%0d err=%0b code=%02h ext=%0b rel=%0b, expected cyc=%0d err=%0b code=%02h ext=%0b rel=%0b",
                              o.cyc, o.err, o.code, o.ext, o.rel, sc + 4, vecs[v].e_err,
                              vecs[v].e_code, vecs[v].e_ext, vecs[v].e_rel));
            end
            obs_q.delete();
            exp_q.delete();
        end

        for (int it = 0; it < 30; it++) begin
            r  = int'($urandom_range(0, 3));
            bp = ($urandom_range(0, 7) == 0);
            code = 8'($urandom_range(0, 255));
            if (r[0]) send_frame(8'hE0, 1'b0, 1'b0, sc);
            if (r[1]) send_frame(8'hF0, 1'b0, 1'b0, sc);
            send_frame(code, bp, 1'b0, sc);
            check_events("rand", 4);
        end

        // Stalled frame with a pending E0: error exactly TIMEOUT cycles after the edge is seen.
        send_frame(8'hE0, 1'b0, 1'b0, sc);
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), fc);
        exp_q.push_back('{fc + 4 + TMO, 1'b1, 8'h00, 1'b0, 1'b0});
        m_ext = 1'b0; m_rel = 1'b0;
        check_events("timeout", TMO + 20);
        send_frame(8'h1C, 1'b0, 1'b0, sc);
        check_events("after_timeout", 4);

        // Reset in the middle of an E0 prefix frame, with an earlier E0 already latched.
        send_frame(8'hE0, 1'b0, 1'b0, sc);
        pe = 8'hE0;
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 4; i++) ps2_bit(pe[i], fc);
        do_reset();
        chk(obs_q.size() == 0, "midreset_no_err", $sformatf("got %0d events, expected 0", obs_q.size()));
        chk(kbd.key_code === 8'h00, "midreset_code", $sformatf("got %h, expected 00", kbd.key_code));
        obs_q.delete();
        exp_q.delete();
        send_frame(8'h1C, 1'b0, 1'b0, sc);
        check_events("after_reset", 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
